// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the synchronous FIFO slice.
//   lvl_w(depth)  -- width of an occupancy count able to hold 0..depth
//   *_DEF         -- default parameter values used by sync_fifo
package fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 16;
  localparam int AF_LVL_DEF = DEPTH_DEF - 2;
  localparam int AE_LVL_DEF = 2;

  // One extra bit over the pointer width so that "completely full" (level
  // == depth) is representable alongside "empty" (level == 0).
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// fifo_mem: simple dual-port storage array for sync_fifo.
//   One synchronous write port and one synchronous read port whose output
//   is registered, so the array maps onto distributed or block RAM.
// Ports:
//   clk    in  1       clock, rising edge
//   rst    in  1       synchronous active-high reset (read register only)
//   we     in  1       write enable
//   waddr  in  ADDR_W  write address
//   wdata  in  DATA_W  write word
//   re     in  1       read enable; rdata loads mem[raddr] on the edge
//   raddr  in  ADDR_W  read address
//   rdata  out DATA_W  registered read word, holds when re=0
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Array contents are deliberately never reset so RAM inference stays legal.
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with level reporting, threshold flags and
// sticky overflow/underflow error bits. Storage lives in fifo_mem; all
// control state (pointers, level, error bits, read-valid) lives here.
// Ports:
//   clk           in  1       sole clock, rising edge
//   rst           in  1       synchronous active-high reset, highest priority
//   wr_en/wr_data in  1/DATA_W write request and word
//   rd_en         in  1       read request
//   rd_data       out DATA_W  registered read word, holds between reads
//   rd_valid      out 1       rd_data was popped on the previous edge
//   full/empty    out 1       level == DEPTH / level == 0
//   almost_full   out 1       level >= AF_LVL
//   almost_empty  out 1       level <= AE_LVL
//   level         out LVL_W   current occupancy
//   overflow      out 1       sticky: write requested while full
//   underflow     out 1       sticky: read requested while empty
//   clr_err       in  1       clears overflow/underflow (a new set wins)
//
// Handshake: wr_en and rd_en are requests with no back-pressure signal of
// their own. A write is accepted on an edge iff wr_en=1 and full=0 as seen
// before that edge; a read is accepted iff rd_en=1 and empty=0 as seen
// before that edge. An accepted read presents its word on rd_data with
// rd_valid=1 for exactly the following cycle. Rejected requests change
// nothing except the sticky error bits.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int AF_LVL = DEPTH - 2,
  parameter int AE_LVL = AE_LVL_DEF,
  parameter int LVL_W  = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] AF_L    = LVL_W'(AF_LVL);
  localparam logic [LVL_W-1:0] AE_L    = LVL_W'(AE_LVL);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             wr_acc;
  logic             rd_acc;

  // Acceptance uses only the registered flags, so a same-cycle read never
  // makes room for a write when full and a same-cycle write never feeds a
  // read when empty.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_valid_d  = rd_acc;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    // Pointers are exactly PTR_W bits wide, so +1 wraps modulo DEPTH.
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Clear first, then set, so a coincident error condition wins.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end
    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset also blocks the memory ports so nothing is written or popped on
  // a reset edge; stored words are abandoned, not erased.
  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc & ~rst),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_acc & ~rst),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign level        = level_q;
  assign rd_valid     = rd_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
  assign full         = (level_q == DEPTH_L);
  assign empty        = (level_q == '0);
  assign almost_full  = (level_q >= AF_L);
  assign almost_empty = (level_q <= AE_L);

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo configured with
// DATA_W=8, DEPTH=4, AF_LVL=3, AE_LVL=1.
module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int AF_LVL = 3;
  localparam int AE_LVL = 1;
  localparam int LVL_W  = 3;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [LVL_W-1:0]  level;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AF_LVL (AF_LVL),
    .AE_LVL (AE_LVL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Drive one cycle of requests, step past the edge, and leave the bench
  // #1 after the edge where registered outputs are stable.
  task automatic drive(input logic wr, input logic [DATA_W-1:0] wd,
                       input logic rd, input logic clr);
    wr_en   = wr;
    wr_data = wd;
    rd_en   = rd;
    clr_err = clr;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic do_reset(input logic wr, input logic rd);
    rst = 1'b1;
    drive(wr, 8'hEE, rd, 1'b1);
    rst = 1'b0;
  endtask

  task automatic push(input logic [DATA_W-1:0] d);
    drive(1'b1, d, 1'b0, 1'b0);
    exp_q.push_back(d);
  endtask

  task automatic check_pop(input string tag);
    logic [DATA_W-1:0] e;
    check({tag, "_valid"}, rd_valid, 1'b1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rd_data, e);
    end
  endtask

  task automatic pop(input string tag);
    drive(1'b0, '0, 1'b1, 1'b0);
    check_pop(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] ae_tab;
  logic [4:0] af_tab;

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; clr_err = 1'b0;
    @(posedge clk); #1;

    // Reset values
    do_reset(1'b0, 1'b0);
    check("rst_level", level, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    check("rst_rd_data", rd_data, 0);

    // Fill / drain
    push(8'h11); push(8'h22); push(8'h33);
    check("fill3_full", full, 0);
    push(8'h44);
    check("fill4_full", full, 1);
    check("fill4_level", level, 4);
    for (int i = 0; i < 4; i++) pop("drain");
    check("drain_empty", empty, 1);
    drive(1'b0, '0, 1'b0, 1'b0);
    check("idle_rd_valid", rd_valid, 0);
    check("idle_rd_hold", rd_data, 8'h44);

    // Overflow, set-wins, clear
    for (int i = 1; i <= 4; i++) push(DATA_W'(i));
    drive(1'b1, 8'h05, 1'b0, 1'b0);
    check("ovf_level", level, 4);
    check("ovf_flag", overflow, 1);
    drive(1'b1, 8'h06, 1'b0, 1'b1);
    check("ovf_set_wins", overflow, 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("ovf_cleared", overflow, 0);
    // Read while full plus write: write must be rejected, level drops to 3
    drive(1'b1, 8'h07, 1'b1, 1'b0);
    check_pop("full_rw");
    check("full_rw_level", level, 3);
    check("full_rw_ovf", overflow, 1);
    for (int i = 0; i < 3; i++) pop("ovf_drain");
    check("ovf_drain_empty", empty, 1);
    drive(1'b0, '0, 1'b0, 1'b1);

    // Underflow with same-cycle write: no fall-through
    drive(1'b1, 8'h5A, 1'b1, 1'b0);
    exp_q.push_back(8'h5A);
    check("unf_rd_valid", rd_valid, 0);
    check("unf_flag", underflow, 1);
    check("unf_level", level, 1);
    pop("unf_read");
    check("unf_sticky", underflow, 1);
    drive(1'b0, '0, 1'b0, 1'b1);
    check("unf_cleared", underflow, 0);

    // Wrap with simultaneous read/write at level 2
    push(8'hA0); push(8'hA1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, DATA_W'(8'hB0 + i), 1'b1, 1'b0);
      exp_q.push_back(DATA_W'(8'hB0 + i));
      check_pop("wrap");
      check("wrap_level", level, 2);
    end
    pop("wrap_tail"); pop("wrap_tail");
    check("wrap_empty", empty, 1);

    // Thresholds: bit n of each table is the flag at level n
    ae_tab = 5'b00011;
    af_tab = 5'b11000;
    for (int n = 0; n <= 4; n++) begin
      if (n > 0) push(DATA_W'(8'hC0 + n));
      check("thr_level", level, n);
      check("thr_ae", almost_empty, ae_tab[n]);
      check("thr_af", almost_full, af_tab[n]);
    end

    // Reset mid-operation at level 3 with requests on the reset edge
    pop("pre_rst");
    check("pre_rst_level", level, 3);
    do_reset(1'b1, 1'b1);
    exp_q.delete();
    check("mid_rst_level", level, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_unf", underflow, 0);
    push(8'hA5);
    pop("post_rst");
    check("post_rst_empty", empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sync_fifo

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data word width in bits.
REQ-002 Parameter DEPTH, default 16, SHALL set the entry count; it SHALL be a power of two and at least 2.
REQ-003 Parameter AF_LVL, default DEPTH-2, SHALL set the almost_full threshold in entries.
REQ-004 Parameter AE_LVL, default 2, SHALL set the almost_empty threshold in entries.
REQ-005 Ports SHALL be as follows, with LVL_W = $clog2(DEPTH)+1. One clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_data  in  DATA_W  write word
- rd_en  in  1  read request
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  rd_data holds a newly popped word this cycle
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_LVL
- almost_empty  out  1  level <= AE_LVL
- level  out  LVL_W  current occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  clears overflow and underflow

Function
REQ-006 A write SHALL be accepted when wr_en=1 and full=0; the word is stored at wr_ptr, and wr_ptr increments modulo DEPTH.
REQ-007 A read SHALL be accepted when rd_en=1 and empty=0; mem[rd_ptr] is registered into rd_data, and rd_ptr increments modulo DEPTH.
REQ-008 Read latency SHALL be one cycle: rd_valid=1 exactly in the cycle after an accepted read, and 0 otherwise.
REQ-009 rd_data SHALL hold its last value when no read is accepted.
REQ-010 Acceptance SHALL be judged on pre-edge state only; when full, a write is rejected even if a read is accepted in the same cycle.
REQ-011 When empty, a read SHALL be rejected even if a write is accepted in the same cycle; no fall-through.
REQ-012 level SHALL update as follows: +1 on write accept only; -1 on read accept only; unchanged when both or neither are accepted.
REQ-013 level SHALL never exceed DEPTH and never go below 0.
REQ-014 full, empty, almost_full and almost_empty SHALL be combinational decodes of the registered level.
REQ-015 overflow SHALL set on wr_en=1 while full=1, and underflow SHALL set on rd_en=1 while empty=1; each stays set until clr_err.
REQ-016 If a set condition and clr_err coincide in one cycle, set SHALL win.
REQ-017 A rejected request SHALL NOT alter the pointers, level or memory.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 with no loss or duplication of data.

Reset
REQ-019 On rst=1 at a clock edge, wr_ptr, rd_ptr and level SHALL go to 0 and rd_data SHALL go to 0.
REQ-020 Resulting reset output values SHALL be: rd_valid=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, and almost_full=(AF_LVL==0).
REQ-021 Reset asserted mid-operation SHALL discard all stored entries and any in-flight read; memory contents are not cleared.
REQ-022 rst SHALL take priority over wr_en, rd_en and clr_err.

Structure
REQ-023 Package fifo_pkg SHALL hold lvl_w(depth), a function returning $clog2(depth)+1, and the default parameter constants.
REQ-024 Storage SHALL be a sub-module fifo_mem: a simple dual-port array with one synchronous write port and one synchronous registered read port, inferable as distributed or block RAM.
REQ-025 Control (pointers, level, flags, error bits) SHALL reside in sync_fifo.

Verification (DATA_W=8, DEPTH=4, AF_LVL=3, AE_LVL=1)
REQ-026 Fill/drain: write 0x11, 0x22, 0x33, 0x44, then read 4 times -> full=1 after the 4th write; rd_data sequence 0x11..0x44, each with rd_valid one cycle after its rd_en; empty=1 at the end.
REQ-027 Overflow: write 5 words without reading -> the 5th is rejected, level stays 4, overflow=1; clr_err pulse -> overflow=0.
REQ-028 Underflow: rd_en while empty with wr_en of 0x5A in the same cycle -> rd_valid=0, underflow=1, level=1; the next read returns 0x5A.
REQ-029 Wrap and simultaneous access: 10 cycles of wr_en and rd_en both asserted after a pre-fill of 2 -> level constant at 2 and data in order across the pointer wrap.
REQ-030 Thresholds: level stepped 0..4 -> almost_empty=1 for level<=1 and almost_full=1 for level>=3.
REQ-031 Reset mid-operation: rst at level=3 -> next cycle level=0, empty=1 and rd_valid=0; a subsequent write/read of 0xA5 returns 0xA5.
